sram_like_arbiter: RTL and testbench

//  Shares one SRAM-like bus port between the core's inst and data request

---
 rtl/sram_like_arbiter_if.sv | 24 ++
 rtl/sram_like_arbiter.sv | 115 +++++++++++
 tb/tb_sram_like_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus port: request/payload in one direction, accept, response
// and read data in the other. Used once for each core port and once for
// the shared memory-side port.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the core's inst and data ports.
// The grant is held while a request waits for addr_ok. An in-order owner
// FIFO remembers which port issued each accepted transaction so that every
// data_ok/rdata is returned to the right master.
module sram_like_arbiter #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          DATA_PRIO = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    sram_like_arbiter_if.slave     inst,
    sram_like_arbiter_if.slave     data,
    sram_like_arbiter_if.master    sram,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   proto_err
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic { OWN_INST = 1'b0, OWN_DATA = 1'b1 } owner_e;

    owner_e        fifo_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          locked_q, locked_d;
    owner_e        lock_id_q, lock_id_d;
    owner_e        last_q, last_d;
    logic          proto_err_q, proto_err_d;

    owner_e        gnt, head;
    logic          gnt_req, full, empty, push, pop;

    // Pick the grantee: a waiting request keeps the bus, otherwise priority or alternation.
    always_comb begin
        gnt = OWN_INST;
        if (locked_q) begin
            gnt = lock_id_q;
        end else if (inst.req && data.req) begin
            if (DATA_PRIO)
                gnt = OWN_DATA;
            else if (last_q == OWN_DATA)
                gnt = OWN_INST;
            else
                gnt = OWN_DATA;
        end else if (data.req) begin
            gnt = OWN_DATA;
        end
    end

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign gnt_req = (gnt == OWN_DATA) ? data.req : inst.req;

    // Full blocks from registered state only, so a same-cycle pop never opens the bus.
    assign sram.req   = gnt_req && !full && !reset;
    assign sram.wr    = (gnt == OWN_DATA) ? data.wr    : inst.wr;
    assign sram.size  = (gnt == OWN_DATA) ? data.size  : inst.size;
    assign sram.addr  = (gnt == OWN_DATA) ? data.addr  : inst.addr;
    assign sram.wstrb = (gnt == OWN_DATA) ? data.wstrb : inst.wstrb;
    assign sram.wdata = (gnt == OWN_DATA) ? data.wdata : inst.wdata;

    assign push = sram.req && sram.addr_ok;
    assign pop  = sram.data_ok && !empty && !reset;
    assign head = fifo_q[rptr_q];

    assign inst.addr_ok = push && (gnt == OWN_INST);
    assign data.addr_ok = push && (gnt == OWN_DATA);
    assign inst.data_ok = pop && (head == OWN_INST);
    assign data.data_ok = pop && (head == OWN_DATA);
    assign inst.rdata   = sram.rdata;
    assign data.rdata   = sram.rdata;

    assign outstanding = count_q;
    assign proto_err   = proto_err_q;

    // Next state of the occupancy count, grant lock, alternation bit and error flag.
    always_comb begin
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        locked_d    = locked_q;
        lock_id_d   = lock_id_q;
        last_d      = last_q;
        proto_err_d = proto_err_q || (sram.data_ok && empty);
        if (push) begin
            locked_d = 1'b0;
            last_d   = gnt;
        end else if (sram.req) begin
            locked_d  = 1'b1;
            lock_id_d = gnt;
        end
    end

    // Register update; reset drops all in-flight transactions.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            locked_q    <= 1'b0;
            lock_id_q   <= OWN_INST;
            last_q      <= OWN_INST;
            proto_err_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= gnt;
                wptr_q         <= wptr_q + AW'(1);
            end
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            count_q     <= count_d;
            locked_q    <= locked_d;
            lock_id_q   <= lock_id_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a data-priority instance exercised with a
// vector table plus multi-cycle sequences, and a round-robin instance for
// the alternation check. Expected owners are queued as requests are issued
// and consumed as responses come back.
module tb_sram_like_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_like_arbiter_if p_inst ();
    sram_like_arbiter_if p_data ();
    sram_like_arbiter_if p_sram ();
    sram_like_arbiter_if r_inst ();
    sram_like_arbiter_if r_data ();
    sram_like_arbiter_if r_sram ();

    logic [2:0] outstanding, r_outstanding;
    logic       proto_err, r_proto_err;

    sram_like_arbiter #(.DEPTH(4), .DATA_PRIO(1'b1)) dut (
        .clock(clock), .reset(reset),
        .inst(p_inst), .data(p_data), .sram(p_sram),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    sram_like_arbiter #(.DEPTH(4), .DATA_PRIO(1'b0)) dut_rr (
        .clock(clock), .reset(reset),
        .inst(r_inst), .data(r_data), .sram(r_sram),
        .outstanding(r_outstanding), .proto_err(r_proto_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        exp_q [$];   // expected response owner, 1 = data

    typedef struct {
        string name;
        logic  ireq, dreq, aok;
        logic  e_sreq, e_iok, e_dok, e_sel;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic idle();
        p_inst.req = 1'b0; p_inst.wr = 1'b0; p_inst.size = 2'd2; p_inst.addr = '0;
        p_inst.wstrb = '0; p_inst.wdata = '0;
        p_data.req = 1'b0; p_data.wr = 1'b0; p_data.size = 2'd2; p_data.addr = '0;
        p_data.wstrb = '0; p_data.wdata = '0;
        p_sram.addr_ok = 1'b0; p_sram.data_ok = 1'b0; p_sram.rdata = '0;
    endtask

    task automatic r_idle();
        r_inst.req = 1'b0; r_inst.wr = 1'b0; r_inst.size = 2'd2; r_inst.addr = '0;
        r_inst.wstrb = '0; r_inst.wdata = '0;
        r_data.req = 1'b0; r_data.wr = 1'b0; r_data.size = 2'd2; r_data.addr = '0;
        r_data.wstrb = '0; r_data.wdata = '0;
        r_sram.addr_ok = 1'b0; r_sram.data_ok = 1'b0; r_sram.rdata = '0;
    endtask

    task automatic rand_payload();
        logic [31:0] r;
        r = $urandom;
        p_inst.wr = r[0]; p_inst.size = r[2:1]; p_inst.wstrb = r[6:3];
        p_data.wr = r[7]; p_data.size = r[9:8]; p_data.wstrb = r[13:10];
        p_inst.addr  = $urandom; p_inst.wdata = $urandom;
        p_data.addr  = $urandom; p_data.wdata = $urandom;
    endtask

    task automatic chk_grant(input string tag, input logic e_sreq, input logic e_iok,
                             input logic e_dok, input logic e_sel);
        chk({tag, ".sram_req"}, 32'(p_sram.req), 32'(e_sreq));
        chk({tag, ".inst_addr_ok"}, 32'(p_inst.addr_ok), 32'(e_iok));
        chk({tag, ".data_addr_ok"}, 32'(p_data.addr_ok), 32'(e_dok));
        if (e_sreq) begin
            if (e_sel) begin
                chk({tag, ".sram_addr"}, p_sram.addr, p_data.addr);
                chk({tag, ".sram_wdata"}, p_sram.wdata, p_data.wdata);
                chk({tag, ".sram_ctl"}, 32'({p_sram.wr, p_sram.size, p_sram.wstrb}),
                    32'({p_data.wr, p_data.size, p_data.wstrb}));
            end else begin
                chk({tag, ".sram_addr"}, p_sram.addr, p_inst.addr);
                chk({tag, ".sram_wdata"}, p_sram.wdata, p_inst.wdata);
                chk({tag, ".sram_ctl"}, 32'({p_sram.wr, p_sram.size, p_sram.wstrb}),
                    32'({p_inst.wr, p_inst.size, p_inst.wstrb}));
            end
        end
    endtask

    task automatic check_resp(input string tag, input logic [31:0] rd);
        logic own;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: response with empty scoreboard", tag);
        end else begin
            own = exp_q.pop_front();
            chk({tag, ".inst_data_ok"}, 32'(p_inst.data_ok), 32'(!own));
            chk({tag, ".data_data_ok"}, 32'(p_data.data_ok), 32'(own));
            chk({tag, ".inst_rdata"}, p_inst.rdata, rd);
            chk({tag, ".data_rdata"}, p_data.rdata, rd);
        end
    endtask

    task automatic respond(input string tag, input logic [31:0] rd);
        p_sram.data_ok = 1'b1;
        p_sram.rdata   = rd;
        settle();
        check_resp(tag, rd);
        tick();
        p_sram.data_ok = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"idle_aok",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"inst_only",  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"data_only",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{"inst_only2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"idle_noaok", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"data_only2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        idle();
        r_idle();
        // reset with a pending request: nothing may be issued or accepted
        p_inst.req = 1'b1;
        p_sram.addr_ok = 1'b1;
        tick();
        tick();
        settle();
        chk("reset.sram_req", 32'(p_sram.req), 32'd0);
        chk("reset.inst_addr_ok", 32'(p_inst.addr_ok), 32'd0);
        chk("reset.outstanding", 32'(outstanding), 32'd0);
        chk("reset.proto_err", 32'(proto_err), 32'd0);
        tick();
        reset = 1'b0;
        idle();

        // single-cycle vectors, each answered and drained before the next
        for (int i = 0; i < 6; i++) begin
            rand_payload();
            p_inst.req = vecs[i].ireq;
            p_data.req = vecs[i].dreq;
            p_sram.addr_ok = vecs[i].aok;
            settle();
            chk_grant(vecs[i].name, vecs[i].e_sreq, vecs[i].e_iok, vecs[i].e_dok, vecs[i].e_sel);
            if (vecs[i].e_iok) exp_q.push_back(1'b0);
            if (vecs[i].e_dok) exp_q.push_back(1'b1);
            tick();
            p_inst.req = 1'b0;
            p_data.req = 1'b0;
            p_sram.addr_ok = 1'b0;
            if (exp_q.size() != 0) respond({vecs[i].name, ".resp"}, $urandom);
            settle();
            chk({vecs[i].name, ".outstanding"}, 32'(outstanding), 32'd0);
            tick();
        end

        // boot fetch: addr_ok after two cycles, response one cycle later
        p_inst.req = 1'b1; p_inst.wr = 1'b0; p_inst.size = 2'd2; p_inst.addr = 32'hBFC0_0000;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("boot.wait", 32'({p_sram.req, p_inst.addr_ok}), 32'b10);
            chk("boot.wait_addr", p_sram.addr, 32'hBFC0_0000);
            tick();
        end
        p_sram.addr_ok = 1'b1;
        settle();
        chk("boot.inst_addr_ok", 32'(p_inst.addr_ok), 32'd1);
        exp_q.push_back(1'b0);
        tick();
        p_inst.req = 1'b0;
        p_sram.addr_ok = 1'b0;
        respond("boot.resp", 32'h3C08_BFAF);

        // grant lock: data request arriving while inst waits must not steal the bus
        rand_payload();
        p_inst.req = 1'b1;
        settle();
        chk("lock.first", 32'({p_sram.req, p_inst.addr_ok}), 32'b10);
        tick();
        p_data.req = 1'b1;
        settle();
        chk_grant("lock.hold", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        p_sram.addr_ok = 1'b1;
        settle();
        chk_grant("lock.accept", 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(1'b0);
        tick();
        p_inst.req = 1'b0;
        settle();
        chk_grant("lock.next", 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(1'b1);
        tick();
        p_data.req = 1'b0;
        p_sram.addr_ok = 1'b0;
        respond("lock.resp0", $urandom);
        respond("lock.resp1", $urandom);

        // simultaneous requests with data priority
        rand_payload();
        p_inst.req = 1'b1;
        p_data.req = 1'b1;
        p_sram.addr_ok = 1'b1;
        settle();
        chk_grant("both.first", 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(1'b1);
        tick();
        p_data.req = 1'b0;
        settle();
        chk_grant("both.second", 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(1'b0);
        tick();
        p_inst.req = 1'b0;
        p_sram.addr_ok = 1'b0;
        respond("both.resp0", $urandom);
        respond("both.resp1", $urandom);

        // fill to DEPTH, then a same-cycle pop must not release the fifth request
        p_inst.req = 1'b1;
        p_sram.addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("full.fill_ok", 32'(p_inst.addr_ok), 32'd1);
            chk("full.fill_cnt", 32'(outstanding), 32'(k));
            exp_q.push_back(1'b0);
            tick();
        end
        settle();
        chk("full.cnt", 32'(outstanding), 32'd4);
        chk("full.sram_req", 32'(p_sram.req), 32'd0);
        chk("full.inst_addr_ok", 32'(p_inst.addr_ok), 32'd0);
        tick();
        p_sram.data_ok = 1'b1;
        p_sram.rdata = 32'hA5A5_0001;
        settle();
        chk("full.pop_sram_req", 32'(p_sram.req), 32'd0);
        check_resp("full.pop", 32'hA5A5_0001);
        tick();
        p_sram.data_ok = 1'b0;
        settle();
        chk("full.after_pop_cnt", 32'(outstanding), 32'd3);
        chk("full.resume_ok", 32'(p_inst.addr_ok), 32'd1);
        exp_q.push_back(1'b0);
        tick();
        p_inst.req = 1'b0;
        p_sram.addr_ok = 1'b0;
        settle();
        chk("full.refill_cnt", 32'(outstanding), 32'd4);
        tick();
        for (int k = 0; k < 4; k++) respond("full.drain", $urandom);
        settle();
        chk("full.drained_cnt", 32'(outstanding), 32'd0);
        tick();

        // stray response with nothing in flight
        p_sram.data_ok = 1'b1;
        p_sram.rdata = 32'hDEAD_BEEF;
        settle();
        chk("stray.data_ok", 32'({p_inst.data_ok, p_data.data_ok}), 32'd0);
        chk("stray.err_before", 32'(proto_err), 32'd0);
        tick();
        p_sram.data_ok = 1'b0;
        settle();
        chk("stray.proto_err", 32'(proto_err), 32'd1);
        tick();

        // reset with three in flight drops them and clears the error
        p_inst.req = 1'b1;
        p_sram.addr_ok = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("rst_mid.cnt_before", 32'(outstanding), 32'd3);
        chk("rst_mid.sram_req", 32'(p_sram.req), 32'd0);
        chk("rst_mid.addr_ok", 32'(p_inst.addr_ok), 32'd0);
        tick();
        reset = 1'b0;
        p_inst.req = 1'b0;
        p_sram.addr_ok = 1'b0;
        settle();
        chk("rst_mid.cnt", 32'(outstanding), 32'd0);
        chk("rst_mid.proto_err", 32'(proto_err), 32'd0);
        tick();

        // late response from an un-reset slave
        p_sram.data_ok = 1'b1;
        settle();
        chk("late.data_ok", 32'({p_inst.data_ok, p_data.data_ok}), 32'd0);
        tick();
        p_sram.data_ok = 1'b0;
        settle();
        chk("late.proto_err", 32'(proto_err), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("late.cleared", 32'(proto_err), 32'd0);
        tick();

        // round-robin instance: continuous contention alternates data, inst, data, inst
        r_inst.req = 1'b1; r_inst.addr = 32'h1000_0000;
        r_data.req = 1'b1; r_data.addr = 32'h2000_0000;
        r_sram.addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr.data_addr_ok", 32'(r_data.addr_ok), 32'(k % 2 == 0));
            chk("rr.inst_addr_ok", 32'(r_inst.addr_ok), 32'(k % 2 == 1));
            chk("rr.sram_addr", r_sram.addr, (k % 2 == 0) ? 32'h2000_0000 : 32'h1000_0000);
            tick();
        end
        r_idle();
        settle();
        chk("rr.outstanding", 32'(r_outstanding), 32'd4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
